// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_t        : controller states
//   RES_*          : one-hot result codes, bit0 = eq, bit1 = gt, bit2 = lt
//   clog2()        : ceiling log2, used to size the digit index counter
package cmp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned RES_W = 3;

   localparam logic [RES_W-1:0] RES_NONE = 3'b000;
   localparam logic [RES_W-1:0] RES_EQ   = 3'b001;
   localparam logic [RES_W-1:0] RES_GT   = 3'b010;
   localparam logic [RES_W-1:0] RES_LT   = 3'b100;

   // Ceiling log2; returns 0 for inputs of 0 or 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_magnitude_comparator_cmp_digit.sv
// Combinational compare of one DIGIT-bit slice of the two operands.
//   a_d, b_d   : digit of operand A / B
//   invert_msb : flip the top bit of both digits (sign digit in signed mode)
//   d_gt, d_lt : digit of A greater / less than digit of B
module cmp_digit
   import cmp_pkg::*;
#(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             invert_msb,
   output logic             d_gt,
   output logic             d_lt
);

   logic [DIGIT-1:0] w_a_m;
   logic [DIGIT-1:0] w_b_m;

   // Flipping the sign bit maps two's complement onto unsigned ordering.
   always_comb begin
      w_a_m            = a_d;
      w_b_m            = b_d;
      w_a_m[DIGIT-1]   = a_d[DIGIT-1] ^ invert_msb;
      w_b_m[DIGIT-1]   = b_d[DIGIT-1] ^ invert_msb;
   end

   assign d_gt = (w_a_m > w_b_m);
   assign d_lt = (w_a_m < w_b_m);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator, MSB digit first, DIGIT bits per clock.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, accepted only while busy = 0
//   a, b           : operands, latched on accept
//   signed_mode    : 1 = two's-complement compare, latched on accept
//   busy           : comparison in progress
//   done           : one-cycle result-valid pulse
//   eq, gt, lt     : one-hot result, held until the next completion
module seq_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DIGIT      = 4,
   parameter int unsigned EARLY_EXIT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int unsigned N     = WIDTH / DIGIT;
   localparam int unsigned IDX_W = (N > 1) ? clog2(N) : 1;

   // Reject unsupported geometries at elaboration.
   if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
      $fatal(1, "seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_t             r_state,  w_state_nxt;
   logic [WIDTH-1:0]   r_a,      w_a_nxt;
   logic [WIDTH-1:0]   r_b,      w_b_nxt;
   logic               r_signed, w_signed_nxt;
   logic [IDX_W-1:0]   r_idx,    w_idx_nxt;
   logic               r_found,  w_found_nxt;
   logic               r_dec_gt, w_dec_gt_nxt;
   logic               r_busy,   w_busy_nxt;
   logic               r_done,   w_done_nxt;
   logic [RES_W-1:0]   r_res,    w_res_nxt;

   logic [WIDTH-1:0]   w_a_sh;
   logic [WIDTH-1:0]   w_b_sh;
   logic               w_invert_msb;
   logic               w_d_gt;
   logic               w_d_lt;
   logic               w_found_now;
   logic               w_gt_now;
   logic               w_finish;

   // Select digit idx of each latched operand.
   assign w_a_sh       = r_a >> (int'(r_idx) * DIGIT);
   assign w_b_sh       = r_b >> (int'(r_idx) * DIGIT);
   assign w_invert_msb = r_signed && (r_idx == IDX_W'(N - 1));

   cmp_digit #(
      .DIGIT (DIGIT)
   ) u_cmp_digit (
      .a_d        (w_a_sh[DIGIT-1:0]),
      .b_d        (w_b_sh[DIGIT-1:0]),
      .invert_msb (w_invert_msb),
      .d_gt       (w_d_gt),
      .d_lt       (w_d_lt)
   );

   // The most significant differing digit decides; later digits cannot override it.
   assign w_found_now = r_found | w_d_gt | w_d_lt;
   assign w_gt_now    = r_found ? r_dec_gt : w_d_gt;
   assign w_finish    = (r_idx == '0) || ((EARLY_EXIT != 0) && w_found_now);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_idx    <= '0;
         r_found  <= 1'b0;
         r_dec_gt <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_res    <= RES_NONE;
      end else begin
         r_state  <= w_state_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_signed <= w_signed_nxt;
         r_idx    <= w_idx_nxt;
         r_found  <= w_found_nxt;
         r_dec_gt <= w_dec_gt_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_res    <= w_res_nxt;
      end
   end

   // Next-state and output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_signed_nxt = r_signed;
      w_idx_nxt    = r_idx;
      w_found_nxt  = r_found;
      w_dec_gt_nxt = r_dec_gt;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_res_nxt    = r_res;

      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_a_nxt      = a;
               w_b_nxt      = b;
               w_signed_nxt = signed_mode;
               w_idx_nxt    = IDX_W'(N - 1);
               w_found_nxt  = 1'b0;
               w_dec_gt_nxt = 1'b0;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = RUN;
            end
         end
         RUN: begin
            if (w_finish) begin
               w_state_nxt = IDLE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               if (!w_found_now) begin
                  w_res_nxt = RES_EQ;
               end else if (w_gt_now) begin
                  w_res_nxt = RES_GT;
               end else begin
                  w_res_nxt = RES_LT;
               end
            end else begin
               w_idx_nxt    = r_idx - IDX_W'(1);
               w_found_nxt  = w_found_now;
               w_dec_gt_nxt = w_gt_now;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign busy = r_busy;
   assign done = r_done;
   assign eq   = r_res[0];
   assign gt   = r_res[1];
   assign lt   = r_res[2];

endmodule
